reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter REG_COUNT, default 32, number of register-file entries (range 2..2^ADDR_W).
REQ-002 SHALL have parameter ADDR_W, default 5, register-file address width.
REQ-003 SHALL have parameter HOLD_CYCLES, default 4, cycles core_rst stays high after clear (range 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset (synchronized reset from upstream synchronizer).
REQ-006 SHALL have port soft_rst_req  input  1  synchronous restart request, sampled only in RUN.
REQ-007 SHALL have port rf_clr_we  output  1  register-file clear write enable.
REQ-008 SHALL have port rf_clr_addr  output  ADDR_W  register-file clear address (data written is always zero, supplied by the consumer).
REQ-009 SHALL have port core_rst  output  1  reset to register file, data memory and control.
REQ-010 SHALL have port pc_rst  output  1  reset to program counter.
REQ-011 SHALL have port boot_done  output  1  high while core is running.
REQ-012 SHALL have port seq_state  output  2  encoded FSM state for debug (RESET=0, CLEAR=1, HOLD=2, RUN=3).

Function
REQ-013 SHALL implement a Moore FSM with states RESET, CLEAR, HOLD, RUN; all outputs decoded from flops only, no input-to-output combinational path.
REQ-014 SHALL in RESET drive rf_clr_we=0, rf_clr_addr=0, core_rst=1, pc_rst=1, boot_done=0, and transition to CLEAR on the next rising edge.
REQ-015 SHALL on entry to CLEAR load rf_clr_addr=1 (x0 never written) and assert rf_clr_we=1.
REQ-016 SHALL in CLEAR increment rf_clr_addr by 1 per cycle, issuing exactly REG_COUNT-1 write cycles at addresses 1..REG_COUNT-1, each address exactly once.
REQ-017 SHALL on the edge where CLEAR holds rf_clr_addr==REG_COUNT-1, enter HOLD with rf_clr_we=0, rf_clr_addr=0, hold counter=0; address never wraps past REG_COUNT-1.
REQ-018 SHALL deassert core_rst on entry to HOLD while keeping pc_rst=1 and boot_done=0.
REQ-019 SHALL in HOLD increment an 8-bit hold counter each cycle and enter RUN on the edge where the counter equals HOLD_CYCLES-1.
REQ-020 SHALL in RUN drive core_rst=0, pc_rst=0, boot_done=1, rf_clr_we=0.
REQ-021 SHALL, when soft_rst_req=1 at a rising edge in RUN, enter RESET on that edge (core_rst=pc_rst=1, boot_done=0 next cycle) and repeat the full sequence.
REQ-022 SHALL ignore soft_rst_req in RESET, CLEAR and HOLD; a request held high across re-entry to RUN restarts again on the first RUN edge.
REQ-023 SHALL reach RUN exactly REG_COUNT+HOLD_CYCLES rising edges after reset deassertion (36 with defaults).

Reset
REQ-024 SHALL on reset=1 asynchronously force state RESET, hold counter 0, rf_clr_addr=0, rf_clr_we=0, core_rst=1, pc_rst=1, boot_done=0, seq_state=0, without waiting for clk.
REQ-025 SHALL on reset asserted mid-CLEAR or mid-HOLD abandon the sequence immediately and restart from RESET after deassertion; no partial state retained.
REQ-026 SHALL hold all outputs at reset values for as long as reset=1, regardless of clk or soft_rst_req.

Verification
REQ-027 SHALL verify power-up: reset high 3 cycles, release -> CLEAR writes addr 1..31 on consecutive cycles, core_rst falls at edge 32, boot_done rises at edge 36.
REQ-028 SHALL verify async reset: assert reset between clock edges during CLEAR at addr 10 -> outputs at reset values before next edge; after release sequence restarts at addr 1.
REQ-029 SHALL verify soft restart: soft_rst_req pulse 1 cycle in RUN -> next cycle seq_state=0, pc_rst=1, boot_done=0; boot_done returns 36 edges later.
REQ-030 SHALL verify ignored requests: soft_rst_req held high during CLEAR and HOLD -> sequence timing unchanged; immediate restart on first RUN edge.
REQ-031 SHALL verify parameter corner: REG_COUNT=2, HOLD_CYCLES=1 -> single write at addr 1, boot_done high 3 edges after reset release.
REQ-032 SHALL verify invariant by assertion: rf_clr_we=1 only in CLEAR with rf_clr_addr in 1..REG_COUNT-1; pc_rst=0 implies core_rst=0.

Source files
------------

// File: rtl/reset_sequencer.sv
// Boot/restart sequencer: after reset it clears register-file entries
// 1..REG_COUNT-1, holds the core in reset for HOLD_CYCLES more cycles, then
// releases the program counter and reports boot_done. A soft restart request
// is honoured only while running. Outputs are decoded purely from flops.
module reset_sequencer #(
  parameter int REG_COUNT   = 32,
  parameter int ADDR_W      = 5,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_rst_req,
  output logic              rf_clr_we,
  output logic [ADDR_W-1:0] rf_clr_addr,
  output logic              core_rst,
  output logic              pc_rst,
  output logic              boot_done,
  output logic [1:0]        seq_state
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_CLEAR = 2'd1,
    S_HOLD  = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_COUNT - 1);
  localparam logic [7:0]        HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        hold_q, hold_d;

  // State, clear address and hold counter; reset wins immediately, no clock needed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      addr_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic; address and counter are zeroed whenever they are idle
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    case (state_q)
      S_RESET: begin
        // x0 is hard-wired zero, so clearing starts at entry 1
        state_d = S_CLEAR;
        addr_d  = ADDR_W'(1);
        hold_d  = '0;
      end
      S_CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_HOLD;
          addr_d  = '0;
          hold_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      S_RUN: begin
        if (soft_rst_req) begin
          state_d = S_RESET;
          addr_d  = '0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = S_RESET;
        addr_d  = '0;
        hold_d  = '0;
      end
    endcase
  end

  // Moore decode of the state register
  always_comb begin
    rf_clr_we   = (state_q == S_CLEAR);
    rf_clr_addr = addr_q;
    core_rst    = (state_q == S_RESET) || (state_q == S_CLEAR);
    pc_rst      = (state_q != S_RUN);
    boot_done   = (state_q == S_RUN);
    seq_state   = state_q;
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default instance (32 entries, hold 4) and a
// corner instance (2 entries, hold 1) share clock, reset and soft request.
// Each is tracked by a model that only counts edges since the sequence began.
module tb_reset_sequencer;

  localparam int RCA = 32, HA = 4, AWA = 5;
  localparam int RCB = 2,  HB = 1, AWB = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic soft_rst_req = 1'b0;

  logic           a_we, a_core, a_pc, a_boot;
  logic [AWA-1:0] a_addr;
  logic [1:0]     a_state;
  logic           b_we, b_core, b_pc, b_boot;
  logic [AWB-1:0] b_addr;
  logic [1:0]     b_state;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b1;

  // Edges since the current sequence started (0 = in RESET)
  int ta = 0;
  int tb = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.REG_COUNT(RCA), .ADDR_W(AWA), .HOLD_CYCLES(HA)) dut_a (
    .clk(clk), .reset(reset), .soft_rst_req(soft_rst_req),
    .rf_clr_we(a_we), .rf_clr_addr(a_addr), .core_rst(a_core),
    .pc_rst(a_pc), .boot_done(a_boot), .seq_state(a_state)
  );

  reset_sequencer #(.REG_COUNT(RCB), .ADDR_W(AWB), .HOLD_CYCLES(HB)) dut_b (
    .clk(clk), .reset(reset), .soft_rst_req(soft_rst_req),
    .rf_clr_we(b_we), .rf_clr_addr(b_addr), .core_rst(b_core),
    .pc_rst(b_pc), .boot_done(b_boot), .seq_state(b_state)
  );

  function automatic logic [13:0] pk(logic we, logic [7:0] a, logic c, logic p,
                                     logic b, logic [1:0] s);
    return {we, a, c, p, b, s};
  endfunction

  // Expected outputs after t edges of a sequence with rc entries and h hold cycles
  function automatic logic [13:0] expv(int t, int rc, int h);
    if (t == 0)        return pk(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 2'd0);
    else if (t < rc)   return pk(1'b1, 8'(t), 1'b1, 1'b1, 1'b0, 2'd1);
    else if (t < rc+h) return pk(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 2'd2);
    else               return pk(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 2'd3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Models: a running sequence counts up to RUN, RUN restarts on a request
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ta <= 0;
      tb <= 0;
    end else begin
      if (ta >= RCA + HA) begin
        if (soft_rst_req) ta <= 0;
      end else ta <= ta + 1;
      if (tb >= RCB + HB) begin
        if (soft_rst_req) tb <= 0;
      end else tb <= tb + 1;
    end
  end

  // Per-cycle comparison against the models plus the structural invariants
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("modelA", pk(a_we, 8'(a_addr), a_core, a_pc, a_boot, a_state), expv(ta, RCA, HA));
      chk("modelB", pk(b_we, 8'(b_addr), b_core, b_pc, b_boot, b_state), expv(tb, RCB, HB));
      chk("invA", 32'((!a_we || (a_state == 2'd1 && a_addr >= 1 && 32'(a_addr) <= RCA-1))
                      && (a_pc || !a_core)), 32'd1);
      chk("invB", 32'((!b_we || (b_state == 2'd1 && b_addr >= 1 && 32'(b_addr) <= RCB-1))
                      && (b_pc || !b_core)), 32'd1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [13:0] RST_VEC = 14'b0_00000000_1_1_0_00;

  initial begin
    // Power-up: reset for 3 cycles, release between edges
    repeat (3) @(posedge clk);
    #1 chk("rstA", pk(a_we, 8'(a_addr), a_core, a_pc, a_boot, a_state), RST_VEC);
    #2 reset = 1'b0;
    step(1);                                   // edge 1
    chk("B_e1_addr", 32'(b_addr), 32'd1);
    chk("B_e1_we", 32'(b_we), 32'd1);
    chk("A_e1_addr", 32'(a_addr), 32'd1);
    step(1);                                   // edge 2
    chk("B_e2_state", 32'(b_state), 32'd2);
    chk("B_e2_boot", 32'(b_boot), 32'd0);
    step(1);                                   // edge 3
    chk("B_e3_boot", 32'(b_boot), 32'd1);
    step(28);                                  // edge 31
    chk("A_e31_addr", 32'(a_addr), 32'd31);
    chk("A_e31_core", 32'(a_core), 32'd1);
    step(1);                                   // edge 32
    chk("A_e32_core", 32'(a_core), 32'd0);
    chk("A_e32_pc", 32'(a_pc), 32'd1);
    step(3);                                   // edge 35
    chk("A_e35_boot", 32'(a_boot), 32'd0);
    step(1);                                   // edge 36
    chk("A_e36_boot", 32'(a_boot), 32'd1);

    // Async reset mid-CLEAR at address 10
    #1 reset = 1'b1;
    step(2);
    #2 reset = 1'b0;
    step(10);
    chk("A_addr10", 32'(a_addr), 32'd10);
    #1 reset = 1'b1;
    #1 chk("A_async", pk(a_we, 8'(a_addr), a_core, a_pc, a_boot, a_state), RST_VEC);
    chk("B_async", pk(b_we, 8'(b_addr), b_core, b_pc, b_boot, b_state), RST_VEC);
    step(2);
    #2 reset = 1'b0;
    step(1);
    chk("A_restart_addr", 32'(a_addr), 32'd1);
    chk("A_restart_we", 32'(a_we), 32'd1);
    step(35);
    chk("A_run_again", 32'(a_boot), 32'd1);

    // One-cycle soft restart from RUN
    #2 soft_rst_req = 1'b1;
    step(1);
    chk("A_soft_state", 32'(a_state), 32'd0);
    chk("A_soft_pc", 32'(a_pc), 32'd1);
    chk("A_soft_boot", 32'(a_boot), 32'd0);
    #2 soft_rst_req = 1'b0;
    step(35);
    chk("A_soft_35", 32'(a_boot), 32'd0);
    step(1);
    chk("A_soft_36", 32'(a_boot), 32'd1);

    // Request held high through the whole sequence
    #1 reset = 1'b1;
    #1 soft_rst_req = 1'b1;
    step(1);
    #2 reset = 1'b0;
    step(36);
    chk("A_held_run", 32'(a_state), 32'd3);
    step(1);
    chk("A_held_restart", 32'(a_state), 32'd0);
    #2 soft_rst_req = 1'b0;

    // Randomized soft requests and asynchronous reset pulses
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #3;
      soft_rst_req = ($urandom_range(0, 5) == 0);
      if (reset) begin
        if ($urandom_range(0, 2) == 0) reset = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
      end
    end

    @(posedge clk);
    #1 cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
